reaction_ctrl: RTL and testbench

//  Trial controller for the reaction timer; sits directly upstream of the 6-digit BCD counter.
//  - Arms a trial on START and waits a pseudo-random delay.
//  - Lights LED_GO, then drives the counter's EN with one pulse per millisecond until REACT.
//  - Flags false starts and timeouts.
//  - Drives the counter's CLR at the start of every trial.

---
 rtl/reaction_ctrl_pkg.sv | 25 ++
 rtl/ms_tick_gen.sv | 33 +++
 rtl/reaction_ctrl.sv | 159 +++++++++++++++
 tb/tb_reaction_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_ctrl_pkg.sv
// Shared definitions for the reaction-timer trial controller:
// state encodings, LFSR seed/tap mask and the LFSR step function.
package reaction_ctrl_pkg;

  localparam int unsigned LFSR_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_GO    = 3'd3,
    ST_HOLD  = 3'd4,
    ST_FALSE = 3'd5,
    ST_TOUT  = 3'd6
  } state_e;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Galois right-shift form of taps 16,14,13,11
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {1'b0, cur[LFSR_W-1:1]} ^ (cur[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks (tick high while count == DIV-1).
module ms_tick_gen #(
  parameter int unsigned DIV = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CW'(DIV - 1)) cnt_d = '0;
  end

  // Tick registered one count early so it lines up with count == DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == CW'(DIV - 2));
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer trial controller: random pre-GO delay, ms enable pulses, false start/timeout.
// Macro REACT_FALSE_START_EN: a react pulse during WAIT ends the trial as a false start.
module reaction_ctrl
  import reaction_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 1000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RAND_BITS    = 11,
  parameter int unsigned MAX_WAIT_MS  = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic react_i,
  output logic cnt_en_o,
  output logic cnt_clr_o,
  output logic led_go_o,
  output logic done_o,
  output logic false_start_o,
  output logic timeout_o
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DLY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam int unsigned MS_W  = $clog2(MAX_WAIT_MS + 1);

`ifdef REACT_FALSE_START_EN
  localparam bit FALSE_START_EN = 1'b1;
`else
  localparam bit FALSE_START_EN = 1'b0;
`endif

  logic [2:0]        start_sync_q, react_sync_q;
  logic              start_pulse_q, react_pulse_q;
  logic              tick;
  logic [LFSR_W-1:0] lfsr_q;
  state_e            state_q, state_d;
  logic [DLY_W-1:0]  delay_q, delay_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic              cnt_en_d;
  logic              cnt_en_q, cnt_clr_q, led_go_q, done_q, timeout_q;

  ms_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // Two-flop synchronizers, then a registered rising-edge pulse (3 cycles after the pin)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync_q  <= '0;
      react_sync_q  <= '0;
      start_pulse_q <= 1'b0;
      react_pulse_q <= 1'b0;
      lfsr_q        <= LFSR_SEED;
    end else begin
      start_sync_q  <= {start_sync_q[1:0], start_i};
      react_sync_q  <= {react_sync_q[1:0], react_i};
      start_pulse_q <= start_sync_q[1] & ~start_sync_q[2];
      react_pulse_q <= react_sync_q[1] & ~react_sync_q[2];
      lfsr_q        <= lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      ms_q    <= '0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      ms_q    <= ms_d;
    end
  end

  // Later assignments override earlier ones, which encodes the react/start priorities
  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    ms_d     = ms_q;
    cnt_en_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_pulse_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        delay_d = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
        ms_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (tick) begin
          if (delay_q <= DLY_W'(1)) begin
            delay_d = '0;
            state_d = ST_GO;
          end else begin
            delay_d = delay_q - DLY_W'(1);
          end
        end
        if (FALSE_START_EN && react_pulse_q) state_d = ST_FALSE;
      end
      ST_GO: begin
        if (react_pulse_q) begin
          state_d = ST_HOLD;
        end else if (tick) begin
          if (ms_q == MS_W'(MAX_WAIT_MS)) begin
            state_d = ST_TOUT;
          end else begin
            ms_d     = ms_q + MS_W'(1);
            cnt_en_d = 1'b1;
          end
        end
      end
      ST_HOLD, ST_FALSE, ST_TOUT: begin
        if (start_pulse_q) state_d = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_en_q  <= 1'b0;
      cnt_clr_q <= 1'b0;
      led_go_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= (state_d == ST_ARM);
      led_go_q  <= (state_d == ST_GO);
      done_q    <= (state_d == ST_HOLD);
      timeout_q <= (state_d == ST_TOUT);
    end
  end

`ifdef REACT_FALSE_START_EN
  logic false_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) false_q <= 1'b0;
    else        false_q <= (state_d == ST_FALSE);
  end

  assign false_start_o = false_q;
`else
  assign false_start_o = 1'b0;
`endif

  assign cnt_en_o  = cnt_en_q;
  assign cnt_clr_o = cnt_clr_q;
  assign led_go_o  = led_go_q;
  assign done_o    = done_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl: cycle model of the trial rules plus directed trials.
module tb_reaction_ctrl;

  localparam int unsigned CLK_HZ = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int unsigned MIN_MS = 3;
  localparam int unsigned RBITS = 2;
  localparam int unsigned MAX_MS = 20;
  localparam int DIV = 10;

`ifdef REACT_FALSE_START_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_GO = 3, P_HOLD = 4, P_FALSE = 5, P_TOUT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_i = 1'b0;
  logic react_i = 1'b0;
  logic cnt_en_o, cnt_clr_o, led_go_o, done_o, false_start_o, timeout_o;

  int total = 0;
  int bad = 0;
  int fail_prints = 0;
  bit chk_en = 1'b0;

  reaction_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MIN_DELAY_MS(MIN_MS),
    .RAND_BITS(RBITS), .MAX_WAIT_MS(MAX_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .react_i(react_i),
    .cnt_en_o(cnt_en_o), .cnt_clr_o(cnt_clr_o), .led_go_o(led_go_o),
    .done_o(done_o), .false_start_o(false_start_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  // Model state: phase, cycles since reset, input history, trial counters
  int ph = P_IDLE;
  int ecount = 0;
  int waited = 0;
  int dly = 0;
  int go_ticks = 0;
  bit m_en = 1'b0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [3:0] st_h = '0;
  logic [3:0] rt_h = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; ecount = 0; waited = 0; dly = 0; go_ticks = 0;
      m_en = 1'b0; m_lfsr = 16'hACE1; st_h = '0; rt_h = '0;
    end else begin
      bit sp, rp, tk;
      // an input edge becomes visible three cycles after the pin changes
      sp = st_h[2] & ~st_h[3];
      rp = rt_h[2] & ~rt_h[3];
      tk = ((ecount % DIV) == DIV - 1);
      st_h = {st_h[2:0], start_i};
      rt_h = {rt_h[2:0], react_i};
      m_en = 1'b0;
      case (ph)
        P_IDLE: if (sp) ph = P_ARM;
        P_ARM: begin
          dly = MIN_MS + int'(m_lfsr[1:0]);
          waited = 0;
          go_ticks = 0;
          ph = P_WAIT;
        end
        P_WAIT: begin
          if (FS_EN && rp) ph = P_FALSE;
          else if (tk) begin
            waited++;
            if (waited >= dly) ph = P_GO;
          end
        end
        P_GO: begin
          if (rp) ph = P_HOLD;
          else if (tk) begin
            go_ticks++;
            if (go_ticks > MAX_MS) ph = P_TOUT;
            else m_en = 1'b1;
          end
        end
        default: if (sp) ph = P_ARM;
      endcase
      m_lfsr = lfsr_step(m_lfsr);
      ecount++;
    end
  end

  int en_cnt = 0, clr_cnt = 0, tick_cnt = 0, wait_ticks = 0;
  bit in_wait = 1'b0;

  // Per-cycle compare of all outputs (and the internal tick) against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      logic [6:0] exp_v, act_v;
      logic m_tick;
      m_tick = ((ecount % DIV) == DIV - 1);
      exp_v = {m_tick, m_en, ph == P_ARM, ph == P_GO, ph == P_HOLD, ph == P_FALSE, ph == P_TOUT};
      act_v = {dut.u_tick.tick_o, cnt_en_o, cnt_clr_o, led_go_o, done_o, false_start_o, timeout_o};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        if (fail_prints < 20) begin
          fail_prints++;
          $display("FAIL cycle_outputs cyc=%0d {tick,en,clr,go,done,fs,to} got=%b expected=%b",
                   ecount, act_v, exp_v);
        end
      end
      if (cnt_en_o) en_cnt++;
      if (cnt_clr_o) clr_cnt++;
      if (dut.u_tick.tick_o) tick_cnt++;
      if (in_wait && dut.u_tick.tick_o) wait_ticks++;
      if (cnt_clr_o) in_wait = 1'b1;
      if (led_go_o) in_wait = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_mon();
    en_cnt = 0; clr_cnt = 0; tick_cnt = 0; wait_ticks = 0; in_wait = 1'b0;
  endtask

  function automatic bit sig(input int which);
    case (which)
      0: return led_go_o;
      1: return done_o;
      2: return timeout_o;
      default: return false_start_o;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int limit, input string name);
    int n = 0;
    while (!sig(which) && n < limit) begin step(); n++; end
    total++;
    if (!sig(which)) begin
      bad++;
      $display("FAIL %s: got 0 expected 1 within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_en(input int k, input int limit, input string name);
    int n = 0;
    while (en_cnt < k && n < limit) begin step(); n++; end
    check(name, en_cnt, k);
  endtask

  task automatic press(input bit is_start);
    if (is_start) start_i = 1'b1; else react_i = 1'b1;
    repeat (4) step();
    start_i = 1'b0;
    react_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    check("lfsr_model_step1", int'(lfsr_step(16'hACE1)), int'(16'hE270));
    check("lfsr_model_step2", int'(lfsr_step(16'hE270)), int'(16'h7138));

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: idle after reset, tick every 10th cycle
    clr_mon();
    repeat (100) step();
    check("idle_ticks", tick_cnt, 10);
    check("idle_outputs", int'({cnt_en_o, cnt_clr_o, led_go_o, done_o, false_start_o, timeout_o}), 0);

    // 2: normal trial, react after 5 ms of GO
    clr_mon();
    press(1'b1);
    wait_sig(0, 150, "t2_go");
    check("t2_clr_pulses", clr_cnt, 1);
    total++;
    if (wait_ticks < 3 || wait_ticks > 6) begin
      bad++;
      $display("FAIL t2_wait_ticks: got %0d expected 3..6", wait_ticks);
    end
    wait_en(5, 80, "t2_en_before_react");
    press(1'b0);
    repeat (15) step();
    check("t2_en_total", en_cnt, 5);
    check("t2_done", int'(done_o), 1);
    check("t2_led_off", int'(led_go_o), 0);

    // 3: react during WAIT
    clr_mon();
    press(1'b1);
    press(1'b0);
    repeat (120) step();
`ifdef REACT_FALSE_START_EN
    check("t3_false_start", int'(false_start_o), 1);
    check("t3_no_en", en_cnt, 0);
    check("t3_led_off", int'(led_go_o), 0);
`else
    check("t3_go_reached", int'(led_go_o), 1);
    check("t3_false_tied", int'(false_start_o), 0);
    press(1'b0);
    repeat (6) step();
    check("t3_done", int'(done_o), 1);
`endif

    // 4: no react -> timeout after exactly MAX_MS pulses
    clr_mon();
    press(1'b1);
    wait_sig(2, 400, "t4_timeout");
    repeat (2) step();
    check("t4_en_total", en_cnt, 20);
    check("t4_timeout", int'(timeout_o), 1);
    check("t4_led_off", int'(led_go_o), 0);
    check("t4_clr_pulses", clr_cnt, 1);

    // 5: react edge lands on a tick in GO -> that tick gives no enable
    clr_mon();
    press(1'b1);
    wait_sig(0, 150, "t5_go");
    wait_en(2, 50, "t5_en_before_react");
    while ((ecount % DIV) != 6) step();
    press(1'b0);
    repeat (10) step();
    check("t5_en_total", en_cnt, 2);
    check("t5_done", int'(done_o), 1);

    // 6: reset mid-GO, then a trial and a restart from HOLD
    clr_mon();
    press(1'b1);
    wait_sig(0, 150, "t6_go");
    wait_en(1, 50, "t6_en_before_reset");
    @(posedge clk);
    #2;
    check("t6_led_before_reset", int'(led_go_o), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_outputs", int'({cnt_en_o, cnt_clr_o, led_go_o, done_o, false_start_o, timeout_o}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) step();
    check("t6_idle_after_reset", int'({cnt_en_o, cnt_clr_o, led_go_o, done_o, false_start_o, timeout_o}), 0);
    press(1'b1);
    wait_sig(0, 150, "t6_go2");
    press(1'b0);
    wait_sig(1, 20, "t6_done");
    clr_mon();
    press(1'b1);
    repeat (2) step();
    check("t6_restart_clr", clr_cnt, 1);
    check("t6_done_dropped", int'(done_o), 0);
    wait_sig(0, 150, "t6_go3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
